// File: rtl/hit_trg_pkg.sv
// Shared constants and generator state type for the hit pulse generator.
package hit_trg_pkg;

  localparam int unsigned NUM_CH    = 13;
  localparam int unsigned HIT_WIDTH = 8;
  localparam int unsigned CNT_W     = 16;

  // Accepted pulse-width window seen by the downstream width monitor
  localparam int unsigned WIDTH_MIN = HIT_WIDTH - 4;
  localparam int unsigned WIDTH_MAX = HIT_WIDTH + 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } gen_state_e;

endpackage

// File: rtl/hit_gen_timer.sv
// Loadable down-counter; tc_o is high during the last cycle of a loaded span.
module hit_gen_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  // A span of N cycles holds N, N-1, ..., 1; tc flags the cycle holding 1
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = tc_q;
    if (load_i) begin
      cnt_d = load_val_i;
      tc_d  = (load_val_i == CNT_W'(1));
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      tc_d  = (cnt_q == CNT_W'(2));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/hit_pulse_gen.sv
// Burst hit-pulse generator for the hit lanes with per-pulse trigger strobe.
// Optional macro HIT_ERR_INJECT_EN adds err_every_in to widen every Nth pulse.
module hit_pulse_gen #(
  parameter int unsigned HIT_WIDTH = hit_trg_pkg::HIT_WIDTH,
  parameter int unsigned NUM_CH    = hit_trg_pkg::NUM_CH,
  parameter int unsigned CNT_W     = hit_trg_pkg::CNT_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              stop_in,
  input  logic [NUM_CH-1:0] ch_mask_in,
  input  logic [3:0]        width_in,
  input  logic [CNT_W-1:0]  period_in,
  input  logic [CNT_W-1:0]  burst_len_in,
`ifdef HIT_ERR_INJECT_EN
  input  logic [7:0]        err_every_in,
`endif
  output logic [NUM_CH-1:0] hit_gen_out,
  output logic              ext_trg_gen_out,
  output logic              gen_busy_out,
  output logic              done_out,
  output logic [CNT_W-1:0]  pulse_cnt_out
);

  import hit_trg_pkg::gen_state_e;
  import hit_trg_pkg::ST_IDLE;
  import hit_trg_pkg::ST_HIGH;
  import hit_trg_pkg::ST_LOW;
  import hit_trg_pkg::ST_DONE;

  gen_state_e        state_q;
  logic [NUM_CH-1:0] mask_q, hit_q;
  logic [CNT_W-1:0]  wid_q, per_q, burst_q, cur_w_q, cnt_q;
  logic              trg_q, busy_q, done_q;
  logic              tc;

  logic              start_ok_c, abort_c, high_end_c, low_end_c, last_c;
  logic              next_pulse_c, enter_low_c, load_c;
  logic [CNT_W-1:0]  base_w_c, pulse_w_c, low_len_c, load_val_c;

  assign start_ok_c   = (state_q == ST_IDLE) && start_in && !stop_in;
  assign abort_c      = (state_q != ST_IDLE) && stop_in;
  assign high_end_c   = (state_q == ST_HIGH) && tc;
  assign low_end_c    = (state_q == ST_LOW) && tc;
  assign last_c       = (burst_q != '0) && (cnt_q == burst_q);
  assign next_pulse_c = start_ok_c || (low_end_c && !abort_c && !last_c);
  assign enter_low_c  = high_end_c && !abort_c;

  assign base_w_c  = start_ok_c ? ((width_in == 4'd0) ? CNT_W'(HIT_WIDTH) : CNT_W'(width_in))
                                : wid_q;
  assign low_len_c = (per_q > cur_w_q) ? (per_q - cur_w_q) : CNT_W'(1);

`ifdef HIT_ERR_INJECT_EN
  // Phase counts pulses since the last widened one; restarts at each burst
  logic [7:0] every_q, err_ph_q;
  logic [7:0] every_c, ph_nxt_c;
  logic       err_hit_c;

  assign every_c   = start_ok_c ? err_every_in : every_q;
  assign ph_nxt_c  = (start_ok_c ? 8'd0 : err_ph_q) + 8'd1;
  assign err_hit_c = (every_c != 8'd0) && (ph_nxt_c == every_c);
  assign pulse_w_c = err_hit_c ? CNT_W'(HIT_WIDTH + 6) : base_w_c;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      every_q  <= '0;
      err_ph_q <= '0;
    end else if (next_pulse_c) begin
      every_q  <= every_c;
      err_ph_q <= err_hit_c ? 8'd0 : ph_nxt_c;
    end
  end
`else
  assign pulse_w_c = base_w_c;
`endif

  assign load_c     = next_pulse_c || enter_low_c;
  assign load_val_c = next_pulse_c ? pulse_w_c : low_len_c;

  hit_gen_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .load_i     (load_c),
    .load_val_i (load_val_c),
    .tc_o       (tc)
  );

  // Sequencer: abort beats everything except a new pulse, which excludes abort
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      wid_q   <= '0;
      per_q   <= '0;
      burst_q <= '0;
      cur_w_q <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      trg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      trg_q  <= 1'b0;
      done_q <= 1'b0;
      if (start_ok_c) begin
        mask_q  <= ch_mask_in;
        wid_q   <= base_w_c;
        per_q   <= period_in;
        burst_q <= burst_len_in;
      end
      if (next_pulse_c) begin
        state_q <= ST_HIGH;
        hit_q   <= start_ok_c ? ch_mask_in : mask_q;
        trg_q   <= 1'b1;
        busy_q  <= 1'b1;
        cnt_q   <= start_ok_c ? CNT_W'(1) : cnt_q + CNT_W'(1);
        cur_w_q <= pulse_w_c;
      end else if (abort_c) begin
        state_q <= ST_IDLE;
        hit_q   <= '0;
        busy_q  <= 1'b0;
      end else if (enter_low_c) begin
        state_q <= ST_LOW;
        hit_q   <= '0;
      end else if (low_end_c) begin
        state_q <= ST_DONE;
        done_q  <= 1'b1;
      end else if (state_q == ST_DONE) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign hit_gen_out     = hit_q;
  assign ext_trg_gen_out = trg_q;
  assign gen_busy_out    = busy_q;
  assign done_out        = done_q;
  assign pulse_cnt_out   = cnt_q;

endmodule

// File: tb/tb_hit_pulse_gen.sv
// Self-checking bench for hit_pulse_gen against a cycle-timeline model.
module tb_hit_pulse_gen;

  localparam int unsigned NUM_CH    = 13;
  localparam int unsigned CNT_W     = 16;
  localparam int          HIT_WIDTH = 8;
`ifdef HIT_ERR_INJECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NUM_CH-1:0] hit;
    logic              trg;
    logic              done;
    logic              busy;
    logic [CNT_W-1:0]  cnt;
  } obs_t;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              start_in;
  logic              stop_in;
  logic [NUM_CH-1:0] ch_mask_in;
  logic [3:0]        width_in;
  logic [CNT_W-1:0]  period_in;
  logic [CNT_W-1:0]  burst_len_in;
`ifdef HIT_ERR_INJECT_EN
  logic [7:0]        err_every_in;
`endif
  logic [NUM_CH-1:0] hit_gen_out;
  logic              ext_trg_gen_out;
  logic              gen_busy_out;
  logic              done_out;
  logic [CNT_W-1:0]  pulse_cnt_out;

  int   checks = 0;
  int   passes = 0;
  obs_t exp_q[$];
  int   held_cnt = 0;

  hit_pulse_gen dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .stop_in         (stop_in),
    .ch_mask_in      (ch_mask_in),
    .width_in        (width_in),
    .period_in       (period_in),
    .burst_len_in    (burst_len_in),
`ifdef HIT_ERR_INJECT_EN
    .err_every_in    (err_every_in),
`endif
    .hit_gen_out     (hit_gen_out),
    .ext_trg_gen_out (ext_trg_gen_out),
    .gen_busy_out    (gen_busy_out),
    .done_out        (done_out),
    .pulse_cnt_out   (pulse_cnt_out)
  );

  always #10 clk_in = ~clk_in;

`ifdef HIT_ERR_INJECT_EN
  // Stand-in for the downstream width monitor: counts pulses outside 4..12
  int run_len = 0;
  int err_seen = 0;
  always @(negedge clk_in) begin
    if (hit_gen_out != '0) run_len = run_len + 1;
    else begin
      if (run_len != 0 && (run_len < 4 || run_len > 12)) err_seen = err_seen + 1;
      run_len = 0;
    end
  end
`endif

  function automatic obs_t sample();
    return {hit_gen_out, ext_trg_gen_out, done_out, gen_busy_out, pulse_cnt_out};
  endfunction

  function automatic obs_t mk(logic [NUM_CH-1:0] h, bit t, bit d, bit b, int c);
    obs_t o;
    o.hit = h; o.trg = t; o.done = d; o.busy = b; o.cnt = CNT_W'(c);
    return o;
  endfunction

  function automatic int eff_width(int width, int ee, int p);
    int w;
    w = (width == 0) ? HIT_WIDTH : width;
    if (ee != 0 && (p % ee) == 0) w = HIT_WIDTH + 6;
    return w;
  endfunction

  // Expected per-cycle outputs starting with the first cycle after start
  task automatic build(input logic [NUM_CH-1:0] mask, input int width, input int period,
                       input int burst, input int ee, input int npulses);
    int n, w, l;
    exp_q.delete();
    n = (burst == 0) ? npulses : burst;
    for (int p = 1; p <= n; p++) begin
      w = eff_width(width, ee, p);
      l = (period > w) ? period - w : 1;
      for (int i = 0; i < w; i++) exp_q.push_back(mk(mask, i == 0, 1'b0, 1'b1, p));
      for (int i = 0; i < l; i++) exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, p));
    end
    if (burst != 0) begin
      exp_q.push_back(mk('0, 1'b0, 1'b1, 1'b1, burst));
      exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, burst));
    end
  endtask

  task automatic drive_start(input logic [NUM_CH-1:0] mask, input int width, input int period,
                             input int burst, input int ee, input bit stop);
    @(negedge clk_in);
    ch_mask_in   = mask;
    width_in     = 4'(width);
    period_in    = CNT_W'(period);
    burst_len_in = CNT_W'(burst);
`ifdef HIT_ERR_INJECT_EN
    err_every_in = 8'(ee);
`else
    if (ee != 0) $display("note: err_every ignored");
`endif
    start_in = 1'b1;
    stop_in  = stop;
    @(negedge clk_in);
    start_in = 1'b0;
    stop_in  = 1'b0;
  endtask

  // Runs a finite burst; inputs are scrambled throughout and start is re-pulsed at 'poke'
  task automatic run_burst(input string name, input logic [NUM_CH-1:0] mask, input int width,
                           input int period, input int burst, input int ee, input int poke);
    obs_t o;
    build(mask, width, period, burst, ee, 0);
    drive_start(mask, width, period, burst, ee, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      o = sample();
      checks++;
      if (o !== exp_q[k])
        $display("FAIL %s cyc %0d: got hit=%h trg=%b done=%b busy=%b cnt=%0d, expected hit=%h trg=%b done=%b busy=%b cnt=%0d",
                 name, k, o.hit, o.trg, o.done, o.busy, o.cnt,
                 exp_q[k].hit, exp_q[k].trg, exp_q[k].done, exp_q[k].busy, exp_q[k].cnt);
      else passes++;
      ch_mask_in   = NUM_CH'($urandom);
      width_in     = 4'($urandom);
      period_in    = CNT_W'($urandom);
      burst_len_in = CNT_W'($urandom);
      start_in     = (k == poke);
      @(negedge clk_in);
    end
    start_in = 1'b0;
    held_cnt = burst;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_in = 1'b1; start_in = 1'b0; stop_in = 1'b0;
    ch_mask_in = '0; width_in = '0; period_in = '0; burst_len_in = '0;
`ifdef HIT_ERR_INJECT_EN
    err_every_in = '0;
`endif
    repeat (2) @(negedge clk_in);
    o = sample();
    checks++;
    if (o !== obs_t'(0)) $display("FAIL reset: got %h expected 0", o);
    else passes++;
    rst_in = 1'b0;
  endtask

  task automatic test_basic();
    run_burst("basic", 13'h1FFF, 0, 20, 3, 0, -1);
  endtask

  task automatic test_short_period();
    run_burst("short_period", 13'h0A5A, 5, 4, 2, 0, -1);
  endtask

  task automatic test_zero_mask();
    run_burst("zero_mask", 13'h0000, 3, 7, 2, 0, -1);
  endtask

  task automatic test_start_in_low();
    run_burst("start_in_low", 13'h1234, 8, 20, 2, 0, 8);
  endtask

  task automatic test_abort();
    obs_t o;
    int stop_at;
    stop_at = 3 * 20 + 2;
    build(13'h0F0F, 0, 20, 0, 0, 4);
    drive_start(13'h0F0F, 0, 20, 0, 0, 1'b0);
    for (int k = 0; k <= stop_at; k++) begin
      o = sample();
      checks++;
      if (o !== exp_q[k]) $display("FAIL abort_run cyc %0d: got %h expected %h", k, o, exp_q[k]);
      else passes++;
      stop_in = (k == stop_at);
      @(negedge clk_in);
    end
    stop_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      o = sample();
      checks++;
      if (o !== mk('0, 1'b0, 1'b0, 1'b0, 4)) $display("FAIL abort_idle cyc %0d: got %h expected cnt=4 idle", k, o);
      else passes++;
      @(negedge clk_in);
    end
    held_cnt = 4;
  endtask

  task automatic test_start_stop_together();
    obs_t o;
    drive_start(13'h1FFF, 0, 20, 3, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      o = sample();
      checks++;
      if (o !== mk('0, 1'b0, 1'b0, 1'b0, held_cnt)) $display("FAIL start_stop cyc %0d: got %h expected idle cnt=%0d", k, o, held_cnt);
      else passes++;
      @(negedge clk_in);
    end
  endtask

  task automatic test_async_reset();
    obs_t o;
    drive_start(13'h1FFF, 0, 20, 3, 0, 1'b0);
    @(negedge clk_in);
    #3 rst_in = 1'b1;
    #1 o = sample();
    checks++;
    if (o !== obs_t'(0)) $display("FAIL async_reset: got %h expected 0", o);
    else passes++;
    @(negedge clk_in);
    rst_in = 1'b0;
    held_cnt = 0;
    run_burst("after_reset", 13'h00FF, 4, 9, 2, 0, -1);
  endtask

  task automatic test_random();
    int w, p, b, ee;
    for (int i = 0; i < 6; i++) begin
      w  = $urandom_range(0, 15);
      p  = $urandom_range(1, 25);
      b  = $urandom_range(1, 3);
      ee = ERR_EN ? $urandom_range(0, 3) : 0;
      run_burst("random", (i == 2) ? 13'h0 : NUM_CH'($urandom), w, p, b, ee, -1);
    end
  endtask

`ifdef HIT_ERR_INJECT_EN
  task automatic test_err_inject();
    int before;
    before = err_seen;
    run_burst("err_inject", 13'h1FFF, 0, 20, 4, 2, -1);
    checks++;
    if (err_seen - before !== 2) $display("FAIL err_inject_count: got %0d expected 2", err_seen - before);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short_period();
    test_abort();
    test_start_stop_together();
    test_start_in_low();
    test_zero_mask();
    test_async_reset();
    test_random();
`ifdef HIT_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hit_pulse_gen.md
Name: hit_pulse_gen

Overview:
- Ground-test stimulus source that drives synthetic hit pulses onto the 13 hit lanes.
- These lanes feed the synchronizer and coincidence path, so the hit/trigger counting and width-monitor logic can be exercised end to end.
- Produces bursts of fixed-width, fixed-period pulses on a masked set of channels.
- Also produces a 1-clock external-trigger strobe per pulse and status and count outputs for housekeeping readout.
- Runs at the 50 MHz system clock.

Parameters:
- HIT_WIDTH, 8, default pulse width in clocks (160 ns), used when width_in = 0.
- NUM_CH, 13, number of hit lanes driven.
- CNT_W, 16, width of the period, burst-length and pulse counters.

Ports:
- clk_in  input  1  system clock, 50 MHz.
- rst_in  input  1  reset; one clock; reset is asynchronous and active-high.
- start_in  input  1  1-clock start strobe; sampled only in IDLE.
- stop_in  input  1  1-clock abort strobe; honoured in any state.
- ch_mask_in  input  NUM_CH  lanes to pulse; latched at start.
- width_in  input  4  pulse high time in clocks; 0 selects HIT_WIDTH; latched at start.
- period_in  input  CNT_W  leading-edge to leading-edge spacing in clocks; latched at start.
- burst_len_in  input  CNT_W  pulses per burst; 0 means continuous until stop; latched at start.
- hit_gen_out  output  NUM_CH  generated hit lanes, registered.
- ext_trg_gen_out  output  1  1-clock strobe coincident with the first high cycle of each pulse.
- gen_busy_out  output  1  high while not in IDLE.
- done_out  output  1  1-clock strobe at normal burst completion.
- pulse_cnt_out  output  CNT_W  pulses emitted since last start; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in IDLE, all internal counters 0.
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE:
  - start_in=1 and stop_in=0: latch mask, width and period; load burst_len; clear pulse_cnt; go to HIGH on the next edge.
  - First hit cycle appears one clock after the start_in cycle.
- HIGH:
  - hit_gen_out = latched mask for exactly W clocks, where W = width_in, or HIT_WIDTH if width_in = 0.
  - ext_trg_gen_out = 1 on the first HIGH cycle only.
  - pulse_cnt increments on that same first-HIGH edge.
  - After W cycles, go to LOW.
- LOW:
  - hit_gen_out = 0 for L clocks, where L = period - W if period > W, else L = 1.
  - A low gap of at least one clock always separates pulses.
  - At the end of LOW: if burst_len ≠ 0 and emitted = burst_len, go to DONE; otherwise go to HIGH.
- DONE: done_out = 1 for one clock, then IDLE.
- stop_in in HIGH, LOW or DONE:
  - Next state is IDLE and hit_gen_out = 0 from the next clock, even mid-pulse.
  - done_out is not asserted; pulse_cnt is held.
- start_in and stop_in in the same cycle: stop wins, remain in IDLE.
- start_in outside IDLE: ignored.
- Mask of all zeros: FSM runs normally with silent lanes; strobe and count still advance.
- Emitted counter: wraps at 2^CNT_W. In continuous mode this is harmless because no terminal compare is made.
- Input changes during a burst: have no effect until the next start.
- Arithmetic: period - W uses CNT_W-bit unsigned subtraction, guarded by the period > W compare.

Optional Feature:
- Macro HIT_ERR_INJECT_EN.
- Defined:
  - Adds input err_every_in (8 bits).
  - When err_every_in = N ≠ 0, every Nth pulse of a burst (pulse N, 2N, ...) uses width HIT_WIDTH+6, which is out of the 4..12 accepted window.
  - The LOW time for that pulse is recomputed from the enlarged width using the same rule.
  - N = 0 disables injection.
- Not defined: port absent; all pulses use W.

Decomposition:
- Shared package hit_trg_pkg:
  - NUM_CH, HIT_WIDTH, CNT_W;
  - the width-check window constants (HIT_WIDTH±4);
  - the generator state enum.
- One natural sub-module, hit_gen_timer: loadable down-counter with terminal-count flag, used for both the HIGH and LOW phases.

Test Plan:
- Basic burst: mask=13'h1FFF, width=0, period=20, burst=3, start → three pulses 8 clk high and 12 clk low; first high 1 clk after start; 3 ext_trg strobes; done_out 1 clk after the third LOW; pulse_cnt=3.
- Short period: width=5, period=4, burst=2 → high 5 clk, low 1 clk, high 5 clk; done; pulse_cnt=2.
- Abort: continuous burst (0), stop_in on the 3rd cycle of the 4th pulse → hit_gen_out=0 next clk, IDLE, no done_out, pulse_cnt=4.
- Start and stop together in IDLE → no pulse; gen_busy_out stays 0. start_in during LOW → ignored, sequence unchanged.
- Async reset mid-HIGH → all outputs 0 immediately without waiting for a clock edge; the next start behaves as a fresh burst.
- With HIT_ERR_INJECT_EN, err_every=2, burst=4, width=0 → pulses 2 and 4 are 14 clk wide; the downstream width monitor counts 2 errors.
